// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter draining a byte FIFO back-to-back
// Bytes queue through a valid/ready port; the FSM pops one per frame with no idle gap between frames.

module uart_tx_fifo_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W-1:0] PTR_ONE = (ADDR_W)'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    // Pointers are ADDR_W bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

module uart_tx_fifo #(
    parameter int BPS         = 115200,
    parameter int SYS_CLK_FRE = 100_000_000,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              uart_txd,
    output logic              tx_busy,
    output logic [ADDR_W:0]   fifo_count
);
    localparam int              BPS_CNT    = SYS_CLK_FRE / BPS;
    localparam logic [15:0]     CNT_LAST   = 16'(BPS_CNT - 1);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;

    logic        push;
    logic        pop;
    logic [7:0]  fifo_rdata;
    logic [ADDR_W:0] count;
    logic        fifo_nonempty;
    logic        cnt_done;

    assign tx_ready      = (count != FULL_COUNT);
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (count != '0);
    assign cnt_done      = (clk_cnt_q == CNT_LAST);

    uart_tx_fifo_buf #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .count (count)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_nonempty) state_d = START;
            START:   if (cnt_done) state_d = DATA;
            DATA:    if (cnt_done && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:    if (cnt_done) state_d = fifo_nonempty ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A pop always coincides with loading the shift register and dropping the line for the start bit.
    always_comb begin
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d     = 1'b1;
                clk_cnt_d = '0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (cnt_done) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q != 3'd7) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[bit_idx_d];
                    end else begin
                        txd_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_done) begin
                    clk_cnt_d = '0;
                    txd_d     = 1'b1;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        txd_d   = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            default: begin
                txd_d     = 1'b1;
                clk_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    assign uart_txd   = txd_q;
    assign tx_busy    = (state_q != IDLE) || fifo_nonempty;
    assign fifo_count = count;
endmodule
